// File: rtl/ula_arbitro.sv
// Two-requester arbiter in front of the shared 8-bit ALU.
// Define PRIORIDADE_FIXA_EN for fixed priority (req0 wins ties); default is round-robin.
module ula_arbitro #(
  parameter int LARGURA    = 8,
  parameter int OP_LARGURA = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valido,
  output logic                  req0_pronto,
  input  logic [LARGURA-1:0]    req0_a,
  input  logic [LARGURA-1:0]    req0_b,
  input  logic [OP_LARGURA-1:0] req0_op,
  output logic                  resp0_valido,
  input  logic                  resp0_aceito,
  output logic [LARGURA-1:0]    resp0_resultado,
  output logic                  resp0_zero,
  input  logic                  req1_valido,
  output logic                  req1_pronto,
  input  logic [LARGURA-1:0]    req1_a,
  input  logic [LARGURA-1:0]    req1_b,
  input  logic [OP_LARGURA-1:0] req1_op,
  output logic                  resp1_valido,
  input  logic                  resp1_aceito,
  output logic [LARGURA-1:0]    resp1_resultado,
  output logic                  resp1_zero,
  output logic [LARGURA-1:0]    ula_entrada1,
  output logic [LARGURA-1:0]    ula_entrada2,
  output logic [OP_LARGURA-1:0] ula_sinal,
  input  logic [LARGURA-1:0]    ula_saida,
  input  logic                  ula_zero
);

  typedef enum logic [1:0] {
    OCIOSO,
    EMISSAO,
    RESPOSTA
  } estado_t;

  estado_t estado_q;
  logic    dono_q;
  logic    gnt1;
  logic    ocioso;
  logic    aceita;
  logic    ack;

`ifndef PRIORIDADE_FIXA_EN
  logic    ultimo_q;
`endif

  always_comb begin
    ocioso = (estado_q == OCIOSO);
`ifdef PRIORIDADE_FIXA_EN
    gnt1 = req1_valido & ~req0_valido;
`else
    // on a tie the requester not served last wins
    gnt1 = req1_valido & (~req0_valido | ~ultimo_q);
`endif
    req0_pronto = ocioso & req0_valido & ~gnt1;
    req1_pronto = ocioso & gnt1;
    aceita      = req0_pronto | req1_pronto;
    ack         = dono_q ? (resp1_aceito & resp1_valido)
                         : (resp0_aceito & resp0_valido);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= OCIOSO;
      dono_q          <= 1'b0;
`ifndef PRIORIDADE_FIXA_EN
      ultimo_q        <= 1'b1;
`endif
      ula_entrada1    <= '0;
      ula_entrada2    <= '0;
      ula_sinal       <= '0;
      resp0_valido    <= 1'b0;
      resp0_resultado <= '0;
      resp0_zero      <= 1'b0;
      resp1_valido    <= 1'b0;
      resp1_resultado <= '0;
      resp1_zero      <= 1'b0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          if (aceita) begin
            ula_entrada1 <= gnt1 ? req1_a  : req0_a;
            ula_entrada2 <= gnt1 ? req1_b  : req0_b;
            ula_sinal    <= gnt1 ? req1_op : req0_op;
            dono_q       <= gnt1;
`ifndef PRIORIDADE_FIXA_EN
            ultimo_q     <= gnt1;
`endif
            estado_q     <= EMISSAO;
          end
        end
        EMISSAO: begin
          // ALU output settled on the falling edge mid-cycle
          if (dono_q) begin
            resp1_resultado <= ula_saida;
            resp1_zero      <= ula_zero;
            resp1_valido    <= 1'b1;
          end else begin
            resp0_resultado <= ula_saida;
            resp0_zero      <= ula_zero;
            resp0_valido    <= 1'b1;
          end
          estado_q <= RESPOSTA;
        end
        RESPOSTA: begin
          if (ack) begin
            resp0_valido <= 1'b0;
            resp1_valido <= 1'b0;
            estado_q     <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbitro.sv
// Randomized bench for ula_arbitro with a negedge ALU stub and a
// transaction-level arbitration/result model.
module tb_ula_arbitro;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valido, req0_pronto, resp0_valido, resp0_aceito, resp0_zero;
  logic       req1_valido, req1_pronto, resp1_valido, resp1_aceito, resp1_zero;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op, ula_sinal;
  logic [7:0] resp0_resultado, resp1_resultado;
  logic [7:0] ula_entrada1, ula_entrada2;
  logic [7:0] ula_saida = 8'h00;
  logic       ula_zero  = 1'b1;

  int n_chk = 0;
  int n_ok  = 0;
  int last;
  int grants[$];
  bit         pv[2];
  logic [7:0] pa[2], pb[2];
  logic [2:0] pop[2];
  logic [7:0] res;
  logic       zr;

  ula_arbitro dut (
    .clock(clock), .reset(reset),
    .req0_valido(req0_valido), .req0_pronto(req0_pronto),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valido(resp0_valido), .resp0_aceito(resp0_aceito),
    .resp0_resultado(resp0_resultado), .resp0_zero(resp0_zero),
    .req1_valido(req1_valido), .req1_pronto(req1_pronto),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valido(resp1_valido), .resp1_aceito(resp1_aceito),
    .resp1_resultado(resp1_resultado), .resp1_zero(resp1_zero),
    .ula_entrada1(ula_entrada1), .ula_entrada2(ula_entrada2),
    .ula_sinal(ula_sinal), .ula_saida(ula_saida), .ula_zero(ula_zero)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] alu(input logic [2:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always @(negedge clock) begin
    ula_saida <= alu(ula_sinal, ula_entrada1, ula_entrada2);
    ula_zero  <= (alu(ula_sinal, ula_entrada1, ula_entrada2) == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    req0_valido = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
    req1_valido = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
  endtask

  task automatic new_req(input int r, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
    pv[r] = 1'b1; pa[r] = a; pb[r] = b; pop[r] = op;
  endtask

  task automatic do_op(input int hold, input bit ack_other,
                       output logic [7:0] r_res, output logic r_z);
    int w;
    logic [7:0] ea, eb, er;
    logic [2:0] eo;
    drive();
    #1;
    if (pv[0] && pv[1]) begin
`ifdef PRIORIDADE_FIXA_EN
      w = 0;
`else
      w = (last == 0) ? 1 : 0;
`endif
    end else w = pv[1] ? 1 : 0;
    chk("pronto0", req0_pronto, w == 0);
    chk("pronto1", req1_pronto, w == 1);
    ea = pa[w]; eb = pb[w]; eo = pop[w];
    er = alu(eo, ea, eb);
    step();
    pv[w] = 1'b0;
    last  = w;
    grants.push_back(w);
    drive();
    #1;
    chk("emi_pronto", {req0_pronto, req1_pronto}, 2'b00);
    chk("emi_ula_a", ula_entrada1, ea);
    chk("emi_ula_b", ula_entrada2, eb);
    chk("emi_ula_op", ula_sinal, eo);
    chk("emi_valid", {resp0_valido, resp1_valido}, 2'b00);
    step();
    r_res = (w == 1) ? resp1_resultado : resp0_resultado;
    r_z   = (w == 1) ? resp1_zero : resp0_zero;
    chk("resp_valid", {resp1_valido, resp0_valido}, (w == 1) ? 2'b10 : 2'b01);
    chk("resp_res", r_res, er);
    chk("resp_zero", r_z, er == 8'd0);
    for (int i = 0; i < hold; i++) begin
      if (ack_other) begin
        if (w == 1) resp0_aceito = 1'b1; else resp1_aceito = 1'b1;
      end
      step();
      resp0_aceito = 1'b0; resp1_aceito = 1'b0;
      chk("hold_valid", {resp1_valido, resp0_valido},
          (w == 1) ? 2'b10 : 2'b01);
      chk("hold_res", (w == 1) ? resp1_resultado : resp0_resultado, er);
      chk("hold_zero", (w == 1) ? resp1_zero : resp0_zero, er == 8'd0);
      chk("hold_pronto", {req0_pronto, req1_pronto}, 2'b00);
    end
    if (w == 1) resp1_aceito = 1'b1; else resp0_aceito = 1'b1;
    step();
    resp0_aceito = 1'b0; resp1_aceito = 1'b0;
    chk("ack_drop", {resp0_valido, resp1_valido}, 2'b00);
  endtask

  initial begin
    pv[0] = 0; pv[1] = 0;
    pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; pop[0] = 0; pop[1] = 0;
    resp0_aceito = 0; resp1_aceito = 0;
    drive();
    last  = 1;
    reset = 1'b1;
    repeat (2) step();
    chk("rst_ula", {ula_entrada1, ula_entrada2, 5'b0, ula_sinal}, 32'h0);
    chk("rst_resp", {resp0_valido, resp0_zero, resp1_valido, resp1_zero}, 4'h0);
    chk("rst_res", {resp0_resultado, resp1_resultado}, 16'h0);
    reset = 1'b0;
    step();

    new_req(0, 8'h05, 8'h03, 3'b010);
    do_op(0, 0, res, zr);
    chk("t1_res", res, 8'h08);
    chk("t1_zero", zr, 1'b0);

    new_req(1, 8'h07, 8'h07, 3'b011);
    do_op(0, 0, res, zr);
    chk("t2_res", res, 8'h00);
    chk("t2_zero", zr, 1'b1);

    grants.delete();
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pv[r]) new_req(r, 8'($urandom), 8'($urandom), 3'($urandom));
      do_op(0, 0, res, zr);
    end
`ifdef PRIORIDADE_FIXA_EN
    chk("t3_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0],
                     grants[3][1:0]}, 8'b00_00_00_00);
`else
    chk("t3_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0],
                     grants[3][1:0]}, 8'b00_01_00_01);
`endif
    while (pv[0] || pv[1]) do_op(0, 0, res, zr);

    new_req(0, 8'h3C, 8'h0F, 3'b000);
    do_op(5, 1, res, zr);
    chk("t4_res", res, 8'h0C);

    new_req(0, 8'hFF, 8'h01, 3'b110);
    do_op(0, 0, res, zr);
    chk("t6_inv_res", res, 8'h00);
    chk("t6_inv_zero", zr, 1'b1);
    new_req(0, 8'h02, 8'h09, 3'b100);
    do_op(0, 0, res, zr);
    chk("t6_slt", res, 8'h01);

    new_req(0, 8'h11, 8'h22, 3'b010);
    drive();
    step();
    pv[0] = 1'b0;
    drive();
    reset = 1'b1;
    #1;
    chk("t5_ula", {ula_entrada1, ula_entrada2, 5'b0, ula_sinal}, 32'h0);
    chk("t5_resp", {resp0_valido, resp0_zero, resp1_valido, resp1_zero}, 4'h0);
    chk("t5_res", {resp0_resultado, resp1_resultado}, 16'h0);
    step();
    reset = 1'b0;
    last  = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_noresp", {resp0_valido, resp1_valido}, 2'b00);
    end
    grants.delete();
    new_req(0, 8'h01, 8'h02, 3'b001);
    new_req(1, 8'h04, 8'h08, 3'b001);
    do_op(0, 0, res, zr);
    chk("t5_tie", grants[0], 0);
    chk("t5_res", res, 8'h03);
    while (pv[0] || pv[1]) do_op(0, 0, res, zr);

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pv[r] && $urandom_range(0, 1) == 1)
          new_req(r, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      if (!pv[0] && !pv[1])
        new_req(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                3'($urandom_range(0, 7)));
      do_op(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), res, zr);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
